// File: rtl/angle_bcd_display.sv
// angle_bcd_display
//   Converts a signed WIDTH-bit value into active-low 7-segment patterns:
//   one sign digit plus DIGITS decimal digits. The binary-to-BCD step is a
//   serial shift-and-add-3 engine that takes WIDTH cycles. Leading zeros can
//   optionally be blanked. Values that need more than DIGITS digits show
//   dashes and raise overflow.
//
// Ports
//   clk       clock
//   reset     asynchronous, active-high
//   valid     load request; accepted only while idle
//   angle     signed input, captured with valid
//   busy      high while a conversion is in flight (WIDTH+1 cycles)
//   done      one-cycle pulse when the display outputs update
//   overflow  last conversion did not fit in DIGITS digits
//   signdisp  sign segment pattern (gfedcba, active-low)
//   disp      digit i at disp[7i+6:7i]; digit 0 is the ones place
module angle_bcd_display #(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 3,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid,
    input  logic [WIDTH-1:0]      angle,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [6:0]            signdisp,
    output logic [7*DIGITS-1:0]   disp
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_UPD  = 2'd2;

    localparam logic [6:0] SEG_DASH  = 7'b011_1111;
    localparam logic [6:0] SEG_BLANK = 7'b111_1111;

    logic [1:0]          state;
    logic [WIDTH-1:0]    mag;
    logic [BW-1:0]       bcd;
    logic [BW-1:0]       bcd_adj;
    logic                sign_f;
    logic                ovf_f;
    logic [CW-1:0]       cnt;
    logic [7*DIGITS-1:0] disp_nxt;
    logic [6:0]          sign_nxt;
    logic                seen;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b100_0000;
            4'd1:    seg7 = 7'b111_1001;
            4'd2:    seg7 = 7'b010_0100;
            4'd3:    seg7 = 7'b011_0000;
            4'd4:    seg7 = 7'b001_1001;
            4'd5:    seg7 = 7'b001_0010;
            4'd6:    seg7 = 7'b000_0010;
            4'd7:    seg7 = 7'b111_1000;
            4'd8:    seg7 = 7'b000_0000;
            4'd9:    seg7 = 7'b001_0000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    // add-3 correction on every nibble ahead of the shift
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Display patterns from the finished BCD. Blanking walks down from the
    // top digit and stops at the first nonzero digit; digit 0 always shows.
    always_comb begin
        disp_nxt = '0;
        seen     = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (ovf_f)
                disp_nxt[7*i +: 7] = SEG_DASH;
            else if (BLANK_LZ != 0 && i != 0 && !seen && bcd[4*i +: 4] == 4'd0)
                disp_nxt[7*i +: 7] = SEG_BLANK;
            else
                disp_nxt[7*i +: 7] = seg7(bcd[4*i +: 4]);
            if (bcd[4*i +: 4] != 4'd0)
                seen = 1'b1;
        end
    end

    // a set sign bit always means a nonzero magnitude, so the flag alone decides
    assign sign_nxt = (ovf_f || sign_f) ? SEG_DASH : SEG_BLANK;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            mag      <= '0;
            bcd      <= '0;
            sign_f   <= 1'b0;
            ovf_f    <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            signdisp <= SEG_DASH;
            disp     <= {DIGITS{SEG_DASH}};
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (valid) begin
                        // two's-complement negate; the most negative value
                        // wraps to 2^(WIDTH-1), which is correct as unsigned
                        mag    <= angle[WIDTH-1] ? (~angle + WIDTH'(1)) : angle;
                        bcd    <= '0;
                        sign_f <= angle[WIDTH-1];
                        ovf_f  <= 1'b0;
                        cnt    <= CW'(WIDTH - 1);
                        busy   <= 1'b1;
                        state  <= S_CONV;
                    end
                end
                S_CONV: begin
                    bcd <= {bcd_adj[BW-2:0], mag[WIDTH-1]};
                    mag <= {mag[WIDTH-2:0], 1'b0};
                    // a 1 leaving the top nibble means the value needs another digit
                    if (bcd_adj[BW-1])
                        ovf_f <= 1'b1;
                    if (cnt == '0)
                        state <= S_UPD;
                    else
                        cnt <= cnt - CW'(1);
                end
                S_UPD: begin
                    state    <= S_IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    overflow <= ovf_f;
                    signdisp <= sign_nxt;
                    disp     <= disp_nxt;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_angle_bcd_display.sv
module tb_angle_bcd_display;

    localparam logic [6:0] S0 = 7'b100_0000, S1 = 7'b111_1001, S2 = 7'b010_0100;
    localparam logic [6:0] S3 = 7'b011_0000, S4 = 7'b001_1001, S5 = 7'b001_0010;
    localparam logic [6:0] S6 = 7'b000_0010, S7 = 7'b111_1000, S8 = 7'b000_0000;
    localparam logic [6:0] S9 = 7'b001_0000, DSH = 7'b011_1111, BLK = 7'b111_1111;

    typedef struct {
        logic [6:0]  s;
        logic [20:0] d;
        logic        ovf;
    } exp_t;

    typedef struct {
        int         which;
        logic [7:0] a;
        exp_t       e;
    } vec_t;

    logic clk, reset;
    logic valid0, valid1, valid2;
    logic [7:0] ang0, ang1, ang2;
    logic busy0, busy1, busy2, done0, done1, done2, ovf0, ovf1, ovf2;
    logic [6:0] sd0, sd1, sd2;
    logic [20:0] disp0, disp1;
    logic [13:0] disp2;

    int total = 0;
    int bad   = 0;

    exp_t q0[$], q1[$], q2[$];
    vec_t tbl[$];

    // main configuration
    angle_bcd_display #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(1)) dut0 (
        .clk(clk), .reset(reset), .valid(valid0), .angle(ang0), .busy(busy0),
        .done(done0), .overflow(ovf0), .signdisp(sd0), .disp(disp0));
    // no leading-zero blanking
    angle_bcd_display #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(0)) dut1 (
        .clk(clk), .reset(reset), .valid(valid1), .angle(ang1), .busy(busy1),
        .done(done1), .overflow(ovf1), .signdisp(sd1), .disp(disp1));
    // two digits: overflow cases
    angle_bcd_display #(.WIDTH(8), .DIGITS(2), .BLANK_LZ(1)) dut2 (
        .clk(clk), .reset(reset), .valid(valid2), .angle(ang2), .busy(busy2),
        .done(done2), .overflow(ovf2), .signdisp(sd2), .disp(disp2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", n, act, exp);
        end
    endtask

    function automatic vec_t mk(input int w, input logic [7:0] a, input logic [6:0] s,
                                input logic [6:0] d2, input logic [6:0] d1,
                                input logic [6:0] d0, input logic ovf);
        vec_t v;
        v.which = w;
        v.a     = a;
        v.e.s   = s;
        v.e.d   = {d2, d1, d0};
        v.e.ovf = ovf;
        return v;
    endfunction

    function automatic exp_t ex(input logic [6:0] s, input logic [6:0] d2,
                                input logic [6:0] d1, input logic [6:0] d0, input logic ovf);
        exp_t e;
        e.s = s; e.d = {d2, d1, d0}; e.ovf = ovf;
        return e;
    endfunction

    // scoreboard: each done pops the oldest expectation for that instance
    always @(negedge clk) begin
        exp_t e;
        if (done0) begin
            if (q0.size() == 0) begin total++; bad++; $display("FAIL dut0 unexpected done"); end
            else begin
                e = q0.pop_front();
                chk("dut0 disp", 32'(disp0), 32'(e.d));
                chk("dut0 sign", 32'(sd0), 32'(e.s));
                chk("dut0 ovf", 32'(ovf0), 32'(e.ovf));
                chk("dut0 busy at done", 32'(busy0), 32'd0);
            end
        end
        if (done1) begin
            if (q1.size() == 0) begin total++; bad++; $display("FAIL dut1 unexpected done"); end
            else begin
                e = q1.pop_front();
                chk("dut1 disp", 32'(disp1), 32'(e.d));
                chk("dut1 sign", 32'(sd1), 32'(e.s));
                chk("dut1 ovf", 32'(ovf1), 32'(e.ovf));
            end
        end
        if (done2) begin
            if (q2.size() == 0) begin total++; bad++; $display("FAIL dut2 unexpected done"); end
            else begin
                e = q2.pop_front();
                chk("dut2 disp", 32'(disp2), 32'(e.d[13:0]));
                chk("dut2 sign", 32'(sd2), 32'(e.s));
                chk("dut2 ovf", 32'(ovf2), 32'(e.ovf));
            end
        end
    end

    function automatic logic done_of(input int w);
        case (w)
            0:       return done0;
            1:       return done1;
            default: return done2;
        endcase
    endfunction

    // called at a negedge; returns the negedge count until done (-1 on timeout)
    task automatic send(input int w, input logic [7:0] a, input exp_t e, output int lat);
        case (w)
            0:       begin valid0 = 1'b1; ang0 = a; q0.push_back(e); end
            1:       begin valid1 = 1'b1; ang1 = a; q1.push_back(e); end
            default: begin valid2 = 1'b1; ang2 = a; q2.push_back(e); end
        endcase
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin valid0 = 1'b0; valid1 = 1'b0; valid2 = 1'b0; end
            if (done_of(w)) begin lat = c; break; end
        end
        if (lat < 0) begin
            total++; bad++;
            $display("FAIL dut%0d no done got=none want=done", w);
        end
    endtask

    initial begin
        int lat, nbusy, dat;

        tbl.push_back(mk(0, 8'h80, DSH, S1,  S2,  S8, 1'b0));  // -128
        tbl.push_back(mk(0, 8'h00, BLK, BLK, BLK, S0, 1'b0));  // 0
        tbl.push_back(mk(0, 8'h7F, BLK, S1,  S2,  S7, 1'b0));  // 127
        tbl.push_back(mk(0, 8'hFF, DSH, BLK, BLK, S1, 1'b0));  // -1
        tbl.push_back(mk(0, 8'h64, BLK, S1,  S0,  S0, 1'b0));  // 100
        tbl.push_back(mk(0, 8'h9C, DSH, S1,  S0,  S0, 1'b0));  // -100
        tbl.push_back(mk(0, 8'h0A, BLK, BLK, S1,  S0, 1'b0));  // 10
        tbl.push_back(mk(1, 8'h7F, BLK, S1,  S2,  S7, 1'b0));  // 127, no blanking
        tbl.push_back(mk(1, 8'h05, BLK, S0,  S0,  S5, 1'b0));  // 5
        tbl.push_back(mk(1, 8'hF6, DSH, S0,  S1,  S0, 1'b0));  // -10
        tbl.push_back(mk(2, 8'h7F, DSH, BLK, DSH, DSH, 1'b1)); // 127 overflow
        tbl.push_back(mk(2, 8'h2D, BLK, BLK, S4,  S5, 1'b0));  // 45 right after overflow
        tbl.push_back(mk(2, 8'h63, BLK, BLK, S9,  S9, 1'b0));  // 99 largest fit
        tbl.push_back(mk(2, 8'h64, DSH, BLK, DSH, DSH, 1'b1)); // 100 smallest overflow
        tbl.push_back(mk(2, 8'h9D, DSH, BLK, S9,  S9, 1'b0));  // -99
        tbl.push_back(mk(2, 8'h9C, DSH, BLK, DSH, DSH, 1'b1)); // -100

        reset = 1'b1;
        valid0 = 1'b0; valid1 = 1'b0; valid2 = 1'b0;
        ang0 = '0; ang1 = '0; ang2 = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", 32'(busy0), 32'd0);
        chk("reset done", 32'(done0), 32'd0);
        chk("reset ovf", 32'(ovf0), 32'd0);
        chk("reset sign", 32'(sd0), 32'(DSH));
        chk("reset disp", 32'(disp0), 32'({DSH, DSH, DSH}));
        chk("reset disp2", 32'(disp2), 32'({DSH, DSH}));
        reset = 1'b0;
        @(negedge clk);

        // -90: latency and busy width
        valid0 = 1'b1; ang0 = 8'hA6;
        q0.push_back(ex(DSH, BLK, S9, S0, 1'b0));
        nbusy = 0; dat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) valid0 = 1'b0;
            if (busy0) nbusy++;
            if (done0) begin dat = c; break; end
        end
        chk("-90 busy cycles", 32'(nbusy), 32'd9);
        chk("-90 done latency", 32'(dat), 32'd10);
        @(negedge clk);
        chk("done one pulse", 32'(done0), 32'd0);
        chk("disp holds", 32'(disp0), 32'({BLK, S9, S0}));

        foreach (tbl[i]) send(tbl[i].which, tbl[i].a, tbl[i].e, lat);

        // 30, then 60 offered while busy is dropped
        @(negedge clk);
        valid0 = 1'b1; ang0 = 8'h1E;
        q0.push_back(ex(BLK, BLK, S3, S0, 1'b0));
        dat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) valid0 = 1'b0;
            if (c == 2) begin valid0 = 1'b1; ang0 = 8'h3C; end
            if (c == 3) valid0 = 1'b0;
            if (done0) begin dat = c; break; end
        end
        chk("30 done latency", 32'(dat), 32'd10);
        // valid in the done cycle is accepted
        send(0, 8'hFB, ex(DSH, BLK, BLK, S5, 1'b0), lat);
        chk("-5 done latency", 32'(lat), 32'd10);

        // abort on the 4th CONV cycle
        @(negedge clk);
        valid0 = 1'b1; ang0 = 8'h32;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) valid0 = 1'b0;
        end
        chk("busy before abort", 32'(busy0), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort busy", 32'(busy0), 32'd0);
        chk("abort disp", 32'(disp0), 32'({DSH, DSH, DSH}));
        chk("abort sign", 32'(sd0), 32'(DSH));
        chk("abort ovf2", 32'(ovf2), 32'd0);
        @(negedge clk);
        // valid coincident with reset release
        reset = 1'b0;
        send(0, 8'h3C, ex(BLK, BLK, S6, S0, 1'b0), lat);
        chk("post-reset latency", 32'(lat), 32'd10);
        send(2, 8'h2D, ex(BLK, BLK, S4, S5, 1'b0), lat);

        repeat (3) @(negedge clk);
        chk("q0 drained", 32'(q0.size()), 32'd0);
        chk("q1 drained", 32'(q1.size()), 32'd0);
        chk("q2 drained", 32'(q2.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
